seg7_scan_reader: RTL

Receive-side counterpart of the hex-to-7-segment encoder. It monitors a time-multiplexed, active-low 7-segment display bus (anodes plus segments) and reconstructs the hex nibble shown on each digit. It rejects scan transients with a stability filter and flags malformed bus states. It sits in the simulation top as a display monitor and self-check, so the bench can read decoded digits instead of raw segment patterns.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_to_hex.sv | 21 ++
 rtl/seg7_scan_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low code table, blank pattern, error bit positions
// and the bus-state classification used by the scan reader.
package seg7_pkg;

    // seg_n bit order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int unsigned ERR_MULTI   = 0;
    localparam int unsigned ERR_UNKNOWN = 1;

    typedef enum logic [2:0] {
        ClsIdle,
        ClsCommit,
        ClsBlank,
        ClsBadPat,
        ClsMulti
    } cls_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_CODE[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Monitors a multiplexed active-low 7-segment bus and reconstructs the nibble per digit,
// committing only after a stable run and flagging multi-anode or unknown patterns.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned STALE_CYCLES  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [6:0]            seg_n,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic [2:0]            upd_idx,
    output logic                  err,
    output logic [1:0]            err_code
);

    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic                smp_vld_q;
    logic [7:0]          run_q, run_d;
    logic                stable;

    logic [DIGITS-1:0]   low;
    logic                any_low, multi_low;
    logic [2:0]          idx;
    logic                hit;
    logic [3:0]          nib;
    cls_e                cls;
    logic [DIGITS-1:0]   sel;
    logic [DIGITS-1:0]   stale;
    logic [1:0]          err_set;

    logic [4*DIGITS-1:0] digits_q;
    logic [DIGITS-1:0]   valid_q;
    logic                update_q;
    logic [2:0]          upd_idx_q;
    logic                err_q;
    logic [1:0]          err_code_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            an_q      <= '0;
            seg_q     <= '0;
            smp_vld_q <= 1'b0;
            run_q     <= '0;
        end else begin
            an_q      <= an_n;
            seg_q     <= seg_n;
            smp_vld_q <= 1'b1;
            run_q     <= run_d;
        end
    end

    always_comb begin
        run_d = '0;
        if (smp_vld_q && an_n == an_q && seg_n == seg_q) begin
            run_d = (run_q == 8'(STABLE_CYCLES)) ? run_q : run_q + 8'd1;
        end
    end

    // Counter passes through STABLE_CYCLES-1 once per run, so each run classifies once
    assign stable = smp_vld_q && (run_q == 8'(STABLE_CYCLES - 1));

    seg7_to_hex u_to_hex (
        .seg_n  (seg_q),
        .hit    (hit),
        .nibble (nib)
    );

    always_comb begin
        low       = ~an_q;
        any_low   = |low;
        multi_low = |(low & (low - 1'b1));
        idx       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (low[i]) idx = 3'(i);
        end
    end

    always_comb begin
        cls = ClsIdle;
        if (stable && any_low) begin
            if (multi_low)               cls = ClsMulti;
            else if (hit)                cls = ClsCommit;
            else if (seg_q == SEG_BLANK) cls = ClsBlank;
            else                         cls = ClsBadPat;
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            sel[i] = (cls == ClsCommit || cls == ClsBlank) && (idx == 3'(i));
        end
        err_set              = '0;
        err_set[ERR_MULTI]   = (cls == ClsMulti);
        err_set[ERR_UNKNOWN] = (cls == ClsBadPat);
    end

    if (STALE_CYCLES > 0) begin : g_age
        localparam int unsigned AW = (STALE_CYCLES < 2) ? 1 : $clog2(STALE_CYCLES + 1);
        logic [AW-1:0] age_q [DIGITS];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < DIGITS; i++) age_q[i] <= '0;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i])                              age_q[i] <= '0;
                    else if (age_q[i] != AW'(STALE_CYCLES)) age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end

        // Fires on the edge the counter reaches STALE_CYCLES; a same-cycle commit wins
        always_comb begin
            stale = '0;
            for (int i = 0; i < DIGITS; i++) begin
                stale[i] = (age_q[i] == AW'(STALE_CYCLES - 1)) && !sel[i];
            end
        end
    end else begin : g_no_age
        assign stale = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q   <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            upd_idx_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel[i] && cls == ClsCommit) begin
                    digits_q[4*i +: 4] <= nib;
                    valid_q[i]         <= 1'b1;
                end else if (sel[i] || stale[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            update_q <= |sel;
            if (|sel) upd_idx_q <= idx;
            err_q      <= (err_q & ~err_clr) | (|err_set);
            err_code_q <= (err_code_q & ~{2{err_clr}}) | err_set;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign upd_idx     = upd_idx_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule
